// File: rtl/acc_stream_reader.sv
// Accumulator SRAM read initiator: drains a contiguous word range into a valid/ready stream.
// Optional macro ACC_CLEAR_ON_READ_EN zeroes each word with a write in the cycle after its read.
module acc_stream_reader #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ram_en_o,
    output logic              ram_wen_o,
    output logic [ADDR_W-1:0] ram_r_addr_o,
    output logic [ADDR_W-1:0] ram_w_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o
);
    localparam int IDX_W = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [LEN_W-1:0]  remain_q;
    logic              zero_done_q;
    logic              inflight_q, inflight_last_q;
    logic              head_v_q, head_last_q, tail_v_q, tail_last_q;
    logic [DATA_W-1:0] head_data_q, tail_data_q;

    logic              pop, issue, final_issue, final_beat, clr_now, to_tail;
    logic [1:0]        occupancy;
    logic              base_unused;

    assign base_unused = ^base_addr_i[1:0];

    // Credit counts the beat leaving this cycle so a full-rate stream has no bubbles.
    assign pop         = head_v_q & m_ready_i;
    assign final_beat  = pop & head_last_q;
    assign occupancy   = {1'b0, head_v_q} + {1'b0, tail_v_q} + {1'b0, inflight_q} - {1'b0, pop};
    assign issue       = (state_q == READ) && (occupancy < 2'd2) && !clr_now && !rst_i;
    assign final_issue = issue && (remain_q == LEN_W'(1));
    assign to_tail     = inflight_q && ((head_v_q && !pop) || (pop && tail_v_q));

`ifdef ACC_CLEAR_ON_READ_EN
    logic             clr_pend_q;
    logic [IDX_W-1:0] clr_idx_q;

    assign clr_now = clr_pend_q && !rst_i;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            clr_pend_q <= 1'b0;
            clr_idx_q  <= '0;
        end else begin
            clr_pend_q <= issue;
            clr_idx_q  <= idx_q;
        end
    end
`else
    assign clr_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i && len_i != '0) state_d = READ;
            READ:    if (final_issue) state_d = DRAIN;
            DRAIN:   if (final_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            idx_q           <= '0;
            remain_q        <= '0;
            zero_done_q     <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            head_v_q        <= 1'b0;
            head_last_q     <= 1'b0;
            head_data_q     <= '0;
            tail_v_q        <= 1'b0;
            tail_last_q     <= 1'b0;
            tail_data_q     <= '0;
        end else begin
            zero_done_q     <= (state_q == IDLE) && start_i && (len_i == '0);
            inflight_q      <= issue;
            inflight_last_q <= final_issue;

            if (state_q == IDLE && start_i) begin
                idx_q    <= base_addr_i[ADDR_W-1:2];
                remain_q <= len_i;
            end else if (issue) begin
                idx_q    <= idx_q + IDX_W'(1);
                remain_q <= remain_q - LEN_W'(1);
            end

            // Head is the presented beat; tail only fills while the head is stalled.
            if (pop && tail_v_q) begin
                head_data_q <= tail_data_q;
                head_last_q <= tail_last_q;
            end else if (inflight_q && (!head_v_q || pop)) begin
                head_data_q <= ram_rdata_i;
                head_last_q <= inflight_last_q;
            end else if (pop) begin
                head_last_q <= 1'b0;
            end
            head_v_q <= (head_v_q && !pop) || tail_v_q || inflight_q;

            if (to_tail) begin
                tail_data_q <= ram_rdata_i;
                tail_last_q <= inflight_last_q;
            end
            tail_v_q <= (tail_v_q && !pop) || to_tail;
        end
    end

    always_comb begin
        ram_en_o     = issue || clr_now;
        ram_wen_o    = !clr_now;
        ram_r_addr_o = '0;
        if (issue) ram_r_addr_o = {idx_q, 2'b00};
`ifdef ACC_CLEAR_ON_READ_EN
        else if (clr_now) ram_r_addr_o = {clr_idx_q, 2'b00};
`endif
    end

    assign ram_w_addr_o = ram_r_addr_o;
    assign ram_wdata_o  = '0;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = zero_done_q || final_beat;
    assign m_valid_o    = head_v_q;
    assign m_data_o     = head_data_q;
    assign m_last_o     = head_last_q;

endmodule

// File: tb/tb_acc_stream_reader.sv
// Self-checking bench for acc_stream_reader: behavioural RAM, stream monitor and range model.
// Build with ACC_CLEAR_ON_READ_EN defined to exercise the read-and-clear variant.
module tb_acc_stream_reader;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 12;
    localparam int WORDS  = 1 << (ADDR_W - 2);
`ifdef ACC_CLEAR_ON_READ_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_i, start_i, m_ready_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [LEN_W-1:0]  len_i;
    logic [DATA_W-1:0] ram_rdata_i;
    logic              busy_o, done_o, ram_en_o, ram_wen_o, m_valid_o, m_last_o;
    logic [ADDR_W-1:0] ram_r_addr_o, ram_w_addr_o;
    logic [DATA_W-1:0] ram_wdata_o, m_data_o;

    int checks = 0;
    int failures = 0;

    acc_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .ram_en_o(ram_en_o), .ram_wen_o(ram_wen_o),
        .ram_r_addr_o(ram_r_addr_o), .ram_w_addr_o(ram_w_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_data_o(m_data_o), .m_last_o(m_last_o)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read latency plus bench preload ports.
    logic [DATA_W-1:0] ram [WORDS];
    logic              fill_req = 1'b0;
    logic [DATA_W-1:0] fill_seed = '0;
    logic              poke_en = 1'b0;
    int                poke_idx = 0;
    logic [DATA_W-1:0] poke_val = '0;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= fill_seed ^ (32'(i) * 32'h9E37_79B1);
        end else if (poke_en) begin
            ram[poke_idx] <= poke_val;
        end else if (ram_en_o && !ram_wen_o) begin
            ram[ram_w_addr_o[ADDR_W-1:2]] <= ram_wdata_o;
        end
        if (ram_en_o && ram_wen_o) ram_rdata_i <= ram[ram_r_addr_o[ADDR_W-1:2]];
    end

    // Monitor records what the DUT did; scenario tasks judge the records.
    int          cyc = 0;
    int          rd_addr_q[$], rd_cyc_q[$], wr_addr_q[$], wr_cyc_q[$], beat_cyc_q[$], done_cyc_q[$];
    logic [31:0] beat_data_q[$];
    bit          beat_last_q[$];
    int          start_cyc = 0, busy_fall_cyc = 0, issued = 0, beats = 0;
    int          credit_viol = 0, stab_viol = 0, wr_nz = 0, wen_bad = 0, en_cnt = 0, valid_cnt = 0;
    logic        prev_busy = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_i) begin
            issued     <= 0;
            beats      <= 0;
            prev_busy  <= 1'b0;
            prev_stall <= 1'b0;
        end else begin
            if (ram_en_o && ram_wen_o) begin
                if (issued - beats - int'(m_valid_o && m_ready_i) >= 2) credit_viol <= credit_viol + 1;
                issued <= issued + 1;
                rd_addr_q.push_back(int'(ram_r_addr_o));
                rd_cyc_q.push_back(cyc);
            end
            if (ram_en_o && !ram_wen_o) begin
                wr_addr_q.push_back(int'(ram_w_addr_o));
                wr_cyc_q.push_back(cyc);
            end
            if (ram_wdata_o != '0) wr_nz <= wr_nz + 1;
`ifdef ACC_CLEAR_ON_READ_EN
            if (!ram_wen_o && !ram_en_o) wen_bad <= wen_bad + 1;
`else
            if (!ram_wen_o) wen_bad <= wen_bad + 1;
`endif
            if (ram_en_o) en_cnt <= en_cnt + 1;
            if (m_valid_o) valid_cnt <= valid_cnt + 1;
            if (prev_stall && (!m_valid_o || m_data_o != prev_data || m_last_o != prev_last))
                stab_viol <= stab_viol + 1;
            if (m_valid_o && m_ready_i) begin
                beats <= beats + 1;
                beat_data_q.push_back(m_data_o);
                beat_last_q.push_back(m_last_o);
                beat_cyc_q.push_back(cyc);
            end
            if (done_o) done_cyc_q.push_back(cyc);
            if (start_i && !busy_o) start_cyc <= cyc;
            if (prev_busy && !busy_o) busy_fall_cyc <= cyc;
            prev_busy  <= busy_o;
            prev_stall <= m_valid_o && !m_ready_i;
            prev_data  <= m_data_o;
            prev_last  <= m_last_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] seed);
        fill_seed = seed;
        fill_req  = 1'b1;
        tick();
        fill_req  = 1'b0;
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        poke_idx = idx;
        poke_val = val;
        poke_en  = 1'b1;
        tick();
        poke_en  = 1'b0;
    endtask

    task automatic start_xfer(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
        base_addr_i = base;
        len_i       = len;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: stall cycles 3..8 then toggle.
    task automatic applyStimulus(input int mode, input bit inject, input int budget, output bit timed_out);
        int i;
        i = 1;
        timed_out = 1'b1;
        for (int n = 0; n < budget; n++) begin
            if (!busy_o) begin
                timed_out = 1'b0;
                break;
            end
            case (mode)
                0:       m_ready_i = 1'b1;
                1:       m_ready_i = 1'($urandom_range(0, 1));
                default: m_ready_i = (i < 3) ? 1'b1 : (i <= 8) ? 1'b0 : 1'(i % 2);
            endcase
            if (inject && i == 5) begin
                start_i     = 1'b1;
                base_addr_i = 13'h0800;
                len_i       = 12'd9;
            end else begin
                start_i = 1'b0;
            end
            tick();
            i++;
        end
        start_i   = 1'b0;
        m_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy_o, done_o, ram_en_o, ram_wen_o, m_valid_o, m_last_o} !== 6'b000100) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got=%b want=000100",
                     {busy_o, done_o, ram_en_o, ram_wen_o, m_valid_o, m_last_o});
        end
        checks++;
        if (ram_r_addr_o !== '0 || ram_w_addr_o !== '0) begin
            failures++;
            $display("[TB] FAIL reset_addr got=%h/%h want=0/0", ram_r_addr_o, ram_w_addr_o);
        end
        checks++;
        if (ram_wdata_o !== '0 || m_data_o !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data got=%h/%h want=0/0", ram_wdata_o, m_data_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_basic_stream();
        int b0, d0, cv0;
        bit to;
        for (int k = 0; k < 4; k++) poke(32'h40 + k, 32'(k + 1));
        b0 = beat_data_q.size();
        d0 = done_cyc_q.size();
        cv0 = credit_viol;
        m_ready_i = 1'b1;
        start_xfer(13'h0100, 12'd4);
        applyStimulus(0, 1'b0, 100, to);
        tick();
        tick();
        checks++;
        if (to) begin failures++; $display("[TB] FAIL basic_timeout got=busy want=idle"); end
        checks++;
        if (beat_data_q.size() - b0 != 4) begin
            failures++;
            $display("[TB] FAIL basic_count got=%0d want=4", beat_data_q.size() - b0);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (beat_data_q[b0 + k] !== 32'(k + 1) || beat_last_q[b0 + k] !== (k == 3)) begin
                failures++;
                $display("[TB] FAIL basic_beat%0d got=%h/%0d want=%h/%0d", k,
                         beat_data_q[b0 + k], beat_last_q[b0 + k], k + 1, k == 3);
            end
            checks++;
            if (beat_cyc_q[b0 + k] != start_cyc + 3 + k * STEP) begin
                failures++;
                $display("[TB] FAIL basic_timing%0d got=%0d want=%0d", k,
                         beat_cyc_q[b0 + k] - start_cyc, 3 + k * STEP);
            end
        end
        checks++;
        if (done_cyc_q.size() != d0 + 1 || done_cyc_q[d0] != start_cyc + 3 + 3 * STEP) begin
            failures++;
            $display("[TB] FAIL basic_done got=%0d pulses want=1 at +%0d", done_cyc_q.size() - d0, 3 + 3 * STEP);
        end
        checks++;
        if (busy_fall_cyc != start_cyc + 4 + 3 * STEP) begin
            failures++;
            $display("[TB] FAIL basic_busy_fall got=+%0d want=+%0d", busy_fall_cyc - start_cyc, 4 + 3 * STEP);
        end
        checks++;
        if (credit_viol != cv0) begin
            failures++;
            $display("[TB] FAIL basic_credit got=%0d want=%0d", credit_viol, cv0);
        end
    endtask

    task automatic test_backpressure();
        int b0, r0, cv0, sv0;
        bit to;
        for (int k = 0; k < 4; k++) poke(32'h40 + k, 32'(k + 1));
        b0 = beat_data_q.size();
        r0 = rd_addr_q.size();
        cv0 = credit_viol;
        sv0 = stab_viol;
        start_xfer(13'h0100, 12'd4);
        applyStimulus(2, 1'b1, 200, to);
        tick();
        tick();
        checks++;
        if (to) begin failures++; $display("[TB] FAIL bp_timeout got=busy want=idle"); end
        checks++;
        if (beat_data_q.size() - b0 != 4 || rd_addr_q.size() - r0 != 4) begin
            failures++;
            $display("[TB] FAIL bp_count got=%0d beats %0d reads want=4/4",
                     beat_data_q.size() - b0, rd_addr_q.size() - r0);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (beat_data_q[b0 + k] !== 32'(k + 1) || beat_last_q[b0 + k] !== (k == 3)
                || rd_addr_q[r0 + k] != 32'h100 + 4 * k) begin
                failures++;
                $display("[TB] FAIL bp_beat%0d got=%h/%0d@%h want=%h/%0d@%h", k, beat_data_q[b0 + k],
                         beat_last_q[b0 + k], rd_addr_q[r0 + k], k + 1, k == 3, 32'h100 + 4 * k);
            end
        end
        checks++;
        if (credit_viol != cv0 || stab_viol != sv0) begin
            failures++;
            $display("[TB] FAIL bp_flow got=credit%0d/stable%0d want=0/0", credit_viol - cv0, stab_viol - sv0);
        end
    endtask

    task automatic test_wrap();
        int b0, r0;
        bit to;
        logic [31:0] exp_q[$];
        fill($urandom);
        for (int k = 0; k < 3; k++) exp_q.push_back(ram[(WORDS - 1 + k) % WORDS]);
        b0 = beat_data_q.size();
        r0 = rd_addr_q.size();
        start_xfer(13'h1FFC, 12'd3);
        applyStimulus(1, 1'b0, 200, to);
        tick();
        tick();
        checks++;
        if (to) begin failures++; $display("[TB] FAIL wrap_timeout got=busy want=idle"); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd_addr_q[r0 + k] != ((32'h1FFC + 4 * k) & 32'h1FFF)) begin
                failures++;
                $display("[TB] FAIL wrap_addr%0d got=%h want=%h", k, rd_addr_q[r0 + k], (32'h1FFC + 4 * k) & 32'h1FFF);
            end
            checks++;
            if (beat_data_q[b0 + k] !== exp_q[k]) begin
                failures++;
                $display("[TB] FAIL wrap_data%0d got=%h want=%h", k, beat_data_q[b0 + k], exp_q[k]);
            end
        end
    endtask

    task automatic test_zero_len();
        int en0, v0, d0;
        en0 = en_cnt;
        v0  = valid_cnt;
        d0  = done_cyc_q.size();
        start_xfer(13'($urandom), 12'd0);
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_done got=done%b busy%b want=done1 busy0", done_o, busy_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL zero_pulse got=%b want=0", done_o); end
        for (int n = 0; n < 4; n++) tick();
        checks++;
        if (en_cnt != en0 || valid_cnt != v0 || done_cyc_q.size() != d0 + 1) begin
            failures++;
            $display("[TB] FAIL zero_quiet got=en%0d valid%0d done%0d want=0/0/1",
                     en_cnt - en0, valid_cnt - v0, done_cyc_q.size() - d0);
        end
    endtask

    task automatic test_reset_mid();
        int b0, d0, w0;
        bit to;
        logic [31:0] exp_q[$];
        fill($urandom);
        b0 = beat_data_q.size();
        m_ready_i = 1'b1;
        start_xfer(13'($urandom), 12'd8);
        to = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (beat_data_q.size() >= b0 + 2) begin
                to = 1'b0;
                break;
            end
            tick();
        end
        checks++;
        if (to) begin failures++; $display("[TB] FAIL rstmid_timeout got=no beats want=2 beats"); end
        rst_i = 1'b1;
        tick();
        checks++;
        if ({busy_o, done_o, ram_en_o, ram_wen_o, m_valid_o, m_last_o} !== 6'b000100
            || ram_r_addr_o !== '0 || ram_w_addr_o !== '0 || m_data_o !== '0 || ram_wdata_o !== '0) begin
            failures++;
            $display("[TB] FAIL rstmid_outputs got=%b addr=%h data=%h want=000100 addr=0 data=0",
                     {busy_o, done_o, ram_en_o, ram_wen_o, m_valid_o, m_last_o}, ram_r_addr_o, m_data_o);
        end
        rst_i = 1'b0;
        tick();
        exp_q.push_back(ram[0]);
        exp_q.push_back(ram[1]);
        b0 = beat_data_q.size();
        d0 = done_cyc_q.size();
        w0 = wr_addr_q.size();
        start_xfer(13'h0000, 12'd2);
        applyStimulus(0, 1'b0, 100, to);
        tick();
        tick();
        checks++;
        if (to || beat_data_q.size() - b0 != 2 || done_cyc_q.size() - d0 != 1) begin
            failures++;
            $display("[TB] FAIL rstmid_restart got=%0d beats %0d done want=2/1",
                     beat_data_q.size() - b0, done_cyc_q.size() - d0);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (beat_data_q[b0 + k] !== exp_q[k] || beat_last_q[b0 + k] !== (k == 1)) begin
                failures++;
                $display("[TB] FAIL rstmid_beat%0d got=%h/%0d want=%h/%0d", k,
                         beat_data_q[b0 + k], beat_last_q[b0 + k], exp_q[k], k == 1);
            end
        end
        checks++;
        if (wr_addr_q.size() - w0 != 2 * (STEP - 1)) begin
            failures++;
            $display("[TB] FAIL rstmid_writes got=%0d want=%0d", wr_addr_q.size() - w0, 2 * (STEP - 1));
        end
    endtask

    task automatic test_back_to_back();
        int b0, d0, cv0, sv0, bad;
        bit to;
        logic [ADDR_W-1:0] base;
        logic [LEN_W-1:0] len;
        logic [31:0] exp_q[$];
        fill($urandom);
        cv0 = credit_viol;
        sv0 = stab_viol;
        for (int t = 0; t < 6; t++) begin
            base = 13'($urandom);
            len  = 12'($urandom_range(1, 24));
            exp_q.delete();
            for (int k = 0; k < int'(len); k++) exp_q.push_back(ram[((int'(base) >> 2) + k) % WORDS]);
            b0 = beat_data_q.size();
            d0 = done_cyc_q.size();
            start_xfer(base, len);
            applyStimulus(1, 1'b0, 400, to);
            tick();
            checks++;
            if (to || beat_data_q.size() - b0 != int'(len) || done_cyc_q.size() - d0 != 1) begin
                failures++;
                $display("[TB] FAIL b2b%0d_count got=%0d beats %0d done want=%0d/1", t,
                         beat_data_q.size() - b0, done_cyc_q.size() - d0, len);
            end
            bad = 0;
            for (int k = 0; k < int'(len); k++)
                if (beat_data_q[b0 + k] !== exp_q[k] || beat_last_q[b0 + k] !== (k == int'(len) - 1)) bad++;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("[TB] FAIL b2b%0d_data got=%0d wrong beats want=0 (base=%h len=%0d)", t, bad, base, len);
            end
        end
        checks++;
        if (credit_viol != cv0 || stab_viol != sv0 || wr_nz != 0 || wen_bad != 0) begin
            failures++;
            $display("[TB] FAIL b2b_protocol got=credit%0d stable%0d wdata%0d wen%0d want=0/0/0/0",
                     credit_viol - cv0, stab_viol - sv0, wr_nz, wen_bad);
        end
    endtask

    task automatic test_clear();
        int b0, r0, w0;
        bit to;
        for (int k = 0; k < 4; k++) poke(32'h40 + k, 32'(k + 1));
        r0 = rd_addr_q.size();
        w0 = wr_addr_q.size();
        start_xfer(13'h0100, 12'd4);
        applyStimulus(0, 1'b0, 100, to);
        tick();
        checks++;
`ifdef ACC_CLEAR_ON_READ_EN
        if (to || wr_addr_q.size() - w0 != 4) begin
            failures++;
            $display("[TB] FAIL clear_writes got=%0d want=4", wr_addr_q.size() - w0);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wr_addr_q[w0 + k] != rd_addr_q[r0 + k] || wr_cyc_q[w0 + k] != rd_cyc_q[r0 + k] + 1) begin
                failures++;
                $display("[TB] FAIL clear_pair%0d got=%h@+%0d want=%h@+1", k, wr_addr_q[w0 + k],
                         wr_cyc_q[w0 + k] - rd_cyc_q[r0 + k], rd_addr_q[r0 + k]);
            end
        end
`else
        if (to || wr_addr_q.size() - w0 != 0) begin
            failures++;
            $display("[TB] FAIL clear_writes got=%0d want=0", wr_addr_q.size() - w0);
        end
`endif
        b0 = beat_data_q.size();
        start_xfer(13'h0100, 12'd4);
        applyStimulus(0, 1'b0, 100, to);
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (beat_data_q[b0 + k] !== 32'((k + 1) * (2 - STEP))) begin
                failures++;
                $display("[TB] FAIL clear_pass2_%0d got=%h want=%h", k, beat_data_q[b0 + k], (k + 1) * (2 - STEP));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i       = 1'b1;
        start_i     = 1'b0;
        m_ready_i   = 1'b1;
        base_addr_i = '0;
        len_i       = '0;
        test_reset();
        fill($urandom);
        test_basic_stream();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
